user_pulse_monitor: RTL and testbench
=====================================

Name: user_pulse_monitor

Overview:
Downstream measurement stage for the user-domain pulse generator. It samples the generator's pulse_out (same clk_i domain, no synchroniser), measures period and high time of every complete pulse, and pushes {high, period} records into a small fall-through FIFO for software readback. It also keeps a rising-edge counter and sticky overflow and timeout flags.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
TIMEOUT, 16'hFFFF, period_cnt value at which an in-progress measurement is abandoned; must be at least 2

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
pulse_i  input  1  pulse stream under measurement (generator pulse_out)
enable_i  input  1  measurement enable (level)
clear_i  input  1  synchronous clear (single-cycle strobe)
pop_i  input  1  consume FIFO head; ignored when meas_valid_o=0
meas_valid_o  output  1  FIFO non-empty
meas_high_o  output  16  head record: high cycles
meas_period_o  output  16  head record: period cycles
fifo_level_o  output  $clog2(DEPTH)+1  number of stored records
pulse_count_o  output  16  rising edges seen while enabled; saturates at 16'hFFFF
overflow_o  output  1  sticky: a record was dropped because the FIFO was full
timeout_o  output  1  sticky: TIMEOUT reached without a following edge

Behaviour:
- Reset values (rst_ni=0, asynchronous, active-low; clock clk_i): state=IDLE, pulse_q=0, all counters 0, FIFO empty, all outputs 0.
- Edge detect: rise = pulse_i & ~pulse_q. pulse_q is pulse_i registered every cycle, regardless of state.
- States:
  - IDLE:
    - enable_i=1 -> ARMED.
  - ARMED:
    - rise -> MEASURE.
    - On entry via rise: period_cnt=1; high_cnt=1.
  - MEASURE, no rise:
    - period_cnt+1.
    - high_cnt+pulse_i.
  - MEASURE, rise:
    - Push {high_cnt, period_cnt}.
    - Reload period_cnt=1, high_cnt=1.
    - Stay in MEASURE.
  - MEASURE, period_cnt==TIMEOUT with no rise this cycle:
    - Set timeout_o.
    - No push.
    - -> ARMED.
  - enable_i=0 in any state:
    - -> IDLE next cycle.
    - Partial measurement discarded.
    - FIFO, pulse_count_o and flags retained.
- Resulting record semantics:
  - Edges at cycles t0 and t1 give period=t1-t0.
  - high = number of cycles in [t0, t1-1] with pulse_i=1.
  - The first pulse after arming only starts a measurement; it produces no record.
- pulse_count_o: +1 on every rise while enabled, including the arming edge. Holds at 16'hFFFF.
- FIFO:
  - Fall-through: head visible combinationally while meas_valid_o=1.
  - Pop takes effect at the clock edge.
  - Push when full and no pop: record dropped, overflow_o set.
  - Push and pop in the same cycle when full: both succeed, level unchanged, no overflow.
  - Pop when empty: ignored.
  - Pointers wrap modulo DEPTH.
- clear_i (priority over everything except reset):
  - Empties FIFO; zeroes counters, pulse_count_o, overflow_o, timeout_o.
  - State -> ARMED if enable_i=1, else IDLE.
  - A rise in the clear cycle is not counted.
- Latency: a record is visible on meas_valid_o one cycle after the terminating rise cycle.
- Reset mid-measurement: immediate return to reset values; no record emitted.

Test Plan:
- Generator-style stream, period 4 / high 2, 5 pulses, enable=1, no pops -> 4 records, each {high=2, period=4}; level=4; pulse_count=5; overflow=0.
- Same stream with 7 pulses, DEPTH=4, no pops -> level=4, overflow_o=1, head still {2,4}. Then pop on the cycle a push occurs while full -> level stays 4, no additional loss.
- Stop-phase shape (pulse low 1 cycle, high 3, period 4) -> records {3,4}.
- Constant-high pulse_i after one rise -> no new record; timeout_o=1 when period_cnt reaches TIMEOUT (TIMEOUT=16 in bench); the next rise re-arms without pushing.
- enable_i dropped mid-period, then re-enabled -> the partial pulse produces no record; the first rise after re-enable only arms; FIFO contents intact.
- clear_i asserted on the same cycle as a rise with 2 records stored -> next cycle level=0, pulse_count=0, flags=0; measurement restarts from ARMED. Async reset mid-MEASURE -> all outputs 0.

Source files
------------

// File: rtl/user_pulse_monitor.sv
// user_pulse_monitor: measures period and high time of each complete pulse
// and queues {high, period} records in a small fall-through FIFO.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   pulse_i              pulse stream under measurement
//   enable_i             measurement enable (level)
//   clear_i              sync clear of FIFO, counters and flags
//   pop_i                consume FIFO head
//   meas_valid_o         FIFO non-empty
//   meas_high_o          head record high cycles
//   meas_period_o        head record period cycles
//   fifo_level_o         stored record count
//   pulse_count_o        saturating rise counter
//   overflow_o           sticky record-dropped flag
//   timeout_o            sticky timeout flag
module user_pulse_monitor #(
   parameter int unsigned DEPTH   = 4,
   parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     pulse_i,
   input  logic                     enable_i,
   input  logic                     clear_i,
   input  logic                     pop_i,
   output logic                     meas_valid_o,
   output logic [15:0]              meas_high_o,
   output logic [15:0]              meas_period_o,
   output logic [$clog2(DEPTH):0]   fifo_level_o,
   output logic [15:0]              pulse_count_o,
   output logic                     overflow_o,
   output logic                     timeout_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      MEASURE
   } state_e;

   state_e        state_q, state_d;
   logic          pulse_q;
   logic          rise;
   logic [15:0]   period_q, period_d;
   logic [15:0]   high_q, high_d;
   logic [15:0]   count_q;
   logic          ovf_q, tmo_q;
   logic          push, set_tmo;

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q;
   logic          full, pop_ok, wr_ok, ovf_set;

   assign rise = pulse_i & ~pulse_q;

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      high_d   = high_q;
      push     = 1'b0;
      set_tmo  = 1'b0;
      if (clear_i) begin
         state_d  = enable_i ? ARMED : IDLE;
         period_d = '0;
         high_d   = '0;
      end else if (!enable_i) begin
         // Any partial measurement is abandoned.
         state_d  = IDLE;
         period_d = '0;
         high_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: state_d = ARMED;
            ARMED: begin
               if (rise) begin
                  state_d  = MEASURE;
                  period_d = 16'd1;
                  high_d   = 16'd1;
               end
            end
            MEASURE: begin
               if (rise) begin
                  push     = 1'b1;
                  period_d = 16'd1;
                  high_d   = 16'd1;
               end else if (period_q == TIMEOUT) begin
                  set_tmo  = 1'b1;
                  state_d  = ARMED;
                  period_d = '0;
                  high_d   = '0;
               end else begin
                  period_d = period_q + 16'd1;
                  high_d   = high_q + {15'd0, pulse_i};
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         pulse_q  <= 1'b0;
         period_q <= '0;
         high_q   <= '0;
      end else begin
         state_q  <= state_d;
         pulse_q  <= pulse_i;
         period_q <= period_d;
         high_q   <= high_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         tmo_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (clear_i) begin
         count_q <= '0;
         tmo_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (rise && enable_i && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
         end
         if (set_tmo) begin
            tmo_q <= 1'b1;
         end
         if (ovf_set) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // A pop frees the slot a same-cycle push needs when full.
   assign full    = (level_q == LW'(DEPTH));
   assign pop_ok  = pop_i & meas_valid_o;
   assign wr_ok   = push & (~full | pop_ok);
   assign ovf_set = push & full & ~pop_ok;

   always_ff @(posedge clk_i) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= {high_q, period_q};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (wr_ok && !pop_ok) begin
            level_q <= level_q + LW'(1);
         end else if (pop_ok && !wr_ok) begin
            level_q <= level_q - LW'(1);
         end
      end
   end

   assign meas_valid_o  = (level_q != '0);
   assign meas_high_o   = meas_valid_o ? mem_q[rd_ptr_q][31:16] : '0;
   assign meas_period_o = meas_valid_o ? mem_q[rd_ptr_q][15:0] : '0;
   assign fifo_level_o  = level_q;
   assign pulse_count_o = count_q;
   assign overflow_o    = ovf_q;
   assign timeout_o     = tmo_q;

endmodule

// File: tb/tb_user_pulse_monitor.sv
// tb_user_pulse_monitor: randomized and directed bench for
// user_pulse_monitor, checked against an edge-time reference model.
module tb_user_pulse_monitor;

   localparam int DEPTH = 4;
   localparam int TMO   = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk_i    = 1'b0;
   logic          rst_ni   = 1'b0;
   logic          pulse_i  = 1'b0;
   logic          enable_i = 1'b0;
   logic          clear_i  = 1'b0;
   logic          pop_i    = 1'b0;
   logic          meas_valid_o;
   logic [15:0]   meas_high_o;
   logic [15:0]   meas_period_o;
   logic [LW-1:0] fifo_level_o;
   logic [15:0]   pulse_count_o;
   logic          overflow_o;
   logic          timeout_o;

   user_pulse_monitor #(
      .DEPTH   (DEPTH),
      .TIMEOUT (16'(TMO))
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .pulse_i       (pulse_i),
      .enable_i      (enable_i),
      .clear_i       (clear_i),
      .pop_i         (pop_i),
      .meas_valid_o  (meas_valid_o),
      .meas_high_o   (meas_high_o),
      .meas_period_o (meas_period_o),
      .fifo_level_o  (fifo_level_o),
      .pulse_count_o (pulse_count_o),
      .overflow_o    (overflow_o),
      .timeout_o     (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: remembers the cycle of the last rising edge and the
   // full pulse history; a record is computed from those when the next
   // edge arrives.
   typedef struct packed {
      logic [15:0] hi;
      logic [15:0] per;
   } rec_t;

   rec_t mq[$];
   bit   hist[$];
   int   m_phase;
   int   m_t0;
   int   m_cyc = 0;
   int   m_cnt;
   bit   m_pp, m_ovf, m_to;

   task automatic m_reset();
      mq.delete();
      m_phase = 0;
      m_pp    = 1'b0;
      m_ovf   = 1'b0;
      m_to    = 1'b0;
      m_cnt   = 0;
   endtask

   task automatic m_step(input bit p, input bit en,
                         input bit clr, input bit pop);
      bit   rise;
      bit   pop_ok;
      int   h;
      rec_t r;
      rise   = p & ~m_pp;
      pop_ok = pop && (mq.size() > 0);
      if (clr) begin
         mq.delete();
         m_cnt   = 0;
         m_ovf   = 1'b0;
         m_to    = 1'b0;
         m_phase = en ? 1 : 0;
      end else begin
         if (pop_ok) void'(mq.pop_front());
         if (!en) begin
            m_phase = 0;
         end else begin
            if (rise && m_cnt < 65535) m_cnt++;
            case (m_phase)
               0: m_phase = 1;
               1: begin
                  if (rise) begin
                     m_phase = 2;
                     m_t0    = m_cyc;
                  end
               end
               2: begin
                  if (rise) begin
                     h = 0;
                     for (int i = m_t0; i < m_cyc; i++) h += int'(hist[i]);
                     r.hi  = 16'(h);
                     r.per = 16'(m_cyc - m_t0);
                     if (mq.size() < DEPTH) mq.push_back(r);
                     else m_ovf = 1'b1;
                     m_t0 = m_cyc;
                  end else if (m_cyc - m_t0 == TMO) begin
                     m_to    = 1'b1;
                     m_phase = 1;
                  end
               end
               default: m_phase = 0;
            endcase
         end
      end
      m_pp = p;
      hist.push_back(p);
      m_cyc++;
   endtask

   task automatic compare();
      rec_t h;
      h = (mq.size() != 0) ? mq[0] : '0;
      chk("valid", 32'(meas_valid_o), 32'(mq.size() != 0));
      chk("level", 32'(fifo_level_o), 32'(mq.size()));
      chk("high", 32'(meas_high_o), 32'(h.hi));
      chk("period", 32'(meas_period_o), 32'(h.per));
      chk("count", 32'(pulse_count_o), 32'(m_cnt));
      chk("ovf", 32'(overflow_o), 32'(m_ovf));
      chk("tmo", 32'(timeout_o), 32'(m_to));
   endtask

   // Starts and ends on a falling edge.
   task automatic cyc(input bit p, input bit en,
                      input bit clr, input bit pop);
      compare();
      pulse_i  = p;
      enable_i = en;
      clear_i  = clr;
      pop_i    = pop;
      @(posedge clk_i);
      m_step(p, en, clr, pop);
      @(negedge clk_i);
   endtask

   task automatic gen(input int n, input int per,
                      input int hi, input int lead);
      for (int j = 0; j < n; j++) begin
         for (int k = 0; k < per; k++) begin
            cyc(bit'(k >= lead && k < lead + hi), 1'b1, 1'b0, 1'b0);
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".valid"}, 32'(meas_valid_o), 32'd0);
      chk({tag, ".level"}, 32'(fifo_level_o), 32'd0);
      chk({tag, ".high"}, 32'(meas_high_o), 32'd0);
      chk({tag, ".period"}, 32'(meas_period_o), 32'd0);
      chk({tag, ".count"}, 32'(pulse_count_o), 32'd0);
      chk({tag, ".ovf"}, 32'(overflow_o), 32'd0);
      chk({tag, ".tmo"}, 32'(timeout_o), 32'd0);
   endtask

   int lvl_b;
   bit rp;
   int left;

   initial begin
      repeat (2) @(negedge clk_i);
      chk_zero("rst");
      rst_ni = 1'b1;
      m_reset();

      // Period 4 / high 2, five pulses.
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      gen(5, 4, 2, 0);
      chk("gen5.level", 32'(fifo_level_o), 32'd4);
      chk("gen5.count", 32'(pulse_count_o), 32'd5);
      chk("gen5.ovf", 32'(overflow_o), 32'd0);
      chk("gen5.head", {meas_high_o, meas_period_o}, {16'd2, 16'd4});

      // Two more pulses overflow the FIFO.
      gen(2, 4, 2, 0);
      chk("gen7.level", 32'(fifo_level_o), 32'd4);
      chk("gen7.ovf", 32'(overflow_o), 32'd1);
      chk("gen7.head", {meas_high_o, meas_period_o}, {16'd2, 16'd4});

      // Pop in the same cycle as a push while full.
      cyc(1, 1, 0, 1);
      cyc(1, 1, 0, 0);
      chk("pp.level", 32'(fifo_level_o), 32'd4);
      chk("pp.count", 32'(pulse_count_o), 32'd8);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);

      // Stop-phase shape: low 1, high 3.
      cyc(0, 1, 1, 0);
      chk("clr.level", 32'(fifo_level_o), 32'd0);
      chk("clr.ovf", 32'(overflow_o), 32'd0);
      gen(4, 4, 3, 1);
      chk("stop.level", 32'(fifo_level_o), 32'd3);
      chk("stop.head", {meas_high_o, meas_period_o}, {16'd3, 16'd4});
      repeat (3) cyc(0, 1, 0, 1);
      chk("stop.drain", 32'(fifo_level_o), 32'd0);

      // Constant high after one rise: timeout, then re-arm.
      cyc(0, 1, 1, 0);
      cyc(1, 1, 0, 0);
      repeat (20) cyc(1, 1, 0, 0);
      chk("tmo.flag", 32'(timeout_o), 32'd1);
      chk("tmo.level", 32'(fifo_level_o), 32'd0);
      cyc(0, 1, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk("rearm.level", 32'(fifo_level_o), 32'd0);
      cyc(0, 1, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk("rearm.rec", {meas_high_o, meas_period_o}, {16'd2, 16'd4});
      chk("rearm.lvl1", 32'(fifo_level_o), 32'd1);

      // Enable dropped mid-period, then restored.
      cyc(0, 1, 0, 0);
      cyc(1, 1, 0, 0);
      lvl_b = mq.size();
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk("en.level", 32'(fifo_level_o), 32'(lvl_b));
      chk("en.head", {meas_high_o, meas_period_o}, {16'd2, 16'd4});

      // Clear coinciding with a rise, two records stored.
      cyc(0, 1, 1, 0);
      gen(3, 4, 2, 0);
      chk("cr.pre", 32'(fifo_level_o), 32'd2);
      cyc(1, 1, 1, 0);
      chk("cr.level", 32'(fifo_level_o), 32'd0);
      chk("cr.count", 32'(pulse_count_o), 32'd0);
      chk("cr.flags", {overflow_o, timeout_o}, 32'd0);
      cyc(1, 1, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk("cr.lvl1", 32'(fifo_level_o), 32'd1);
      chk("cr.cnt2", 32'(pulse_count_o), 32'd2);
      chk("cr.rec", {meas_high_o, meas_period_o}, {16'd2, 16'd4});

      // Randomized traffic.
      rp   = 1'b0;
      left = 0;
      for (int n = 0; n < 3000; n++) begin
         if (left == 0) begin
            rp   = ~rp;
            left = ($urandom_range(0, 19) == 0) ?
                   $urandom_range(1, 25) : $urandom_range(1, 6);
         end
         left--;
         cyc(rp,
             bit'($urandom_range(0, 99) < 97),
             bit'($urandom_range(0, 99) < 1),
             bit'($urandom_range(0, 99) < 30));
      end

      // Async reset mid-measurement with records stored.
      cyc(0, 1, 1, 0);
      gen(3, 4, 2, 0);
      chk("ar.pre", 32'(fifo_level_o), 32'd2);
      #2 rst_ni = 1'b0;
      #1 chk_zero("arst");
      pulse_i  = 1'b0;
      enable_i = 1'b0;
      pop_i    = 1'b0;
      repeat (2) @(negedge clk_i);
      chk_zero("arst.hold");
      rst_ni = 1'b1;
      m_reset();
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      gen(3, 4, 2, 0);
      compare();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
